bilinear_interp: RTL and testbench
==================================

Name: bilinear_interp

Overview:
- Consumes the 8-bit horizontal fraction produced by the Divider and runs a bilinear blend of a 2x2 source-pixel neighbourhood.
- Sits directly downstream of the Divider and shares its 8-cycle cycle_cnt cadence.
- Produces one interpolated output pixel per 8-cycle window.
- Uses one shared multiply-accumulate datapath, sequenced by a small FSM.

Parameters:
- PIX_W, 8: pixel width in bits.
- FRAC_W, 8: fraction width in bits. Weight = frac / 2^FRAC_W.
- Only the defaults are verified.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cycle_cnt  in  3  shared window counter, same counter that drives the Divider.
- frac_val  in  FRAC_W  horizontal fraction fx from Divider; valid when cycle_cnt==0.
- frac_y  in  FRAC_W  vertical fraction fy; held by the row sequencer.
- p00  in  PIX_W  top-left pixel.
- p01  in  PIX_W  top-right pixel.
- p10  in  PIX_W  bottom-left pixel.
- p11  in  PIX_W  bottom-right pixel.
- in_valid  in  1  neighbourhood and fractions are valid.
- in_ready  out  1  high in IDLE only.
- pix_out  out  PIX_W  interpolated pixel.
- out_valid  out  1  one-cycle pulse; pix_out is valid during it.

Behaviour:
- Reset: async assert forces the FSM to IDLE, pix_out=0, out_valid=0, and clears acc, top and bot. Reset mid-operation aborts the job silently; no out_valid follows.
- Start condition: in IDLE, in_valid=1 and cycle_cnt==0 at a rising edge. On that edge the block latches p00..p11, fx=frac_val and fy=frac_y, then moves to M0.
- in_valid is ignored in two cases:
  - cycle_cnt!=0;
  - any non-IDLE state (in_ready=0).
- frac_val is sampled only at the start edge. Later changes have no effect.
- Weights: wx0 = 2^FRAC_W - fx and wy0 = 2^FRAC_W - fy, both 9 bits. fx=0 gives wx0=256, an exact pass-through.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5. One state per cycle, then unconditional return to IDLE. The sequence does not watch cycle_cnt once started.
  - M0: acc = p00*wx0
  - M1: top = (acc + p01*fx + 128) >> 8
  - M2: acc = p10*wx0
  - M3: bot = (acc + p11*fx + 128) >> 8
  - M4: acc = top*wy0
  - M5: pix_out <= (acc + bot*fy + 128) >> 8; out_valid <= 1
- Latency: start edge at cycle_cnt 0. M0..M5 occupy cycle_cnt 1..6. out_valid is high during cycle_cnt 7, exactly one cycle. Back-to-back windows therefore give one output per 8 cycles with no bubbles.
- Width rules:
  - acc is 17 bits; maximum value is 255*256 + 128 = 65408.
  - The 8-bit result after the shift never exceeds 255; no saturation is needed.
  - Rounding is round-half-up at every stage.
- pix_out holds its last value between pulses.
- Multiplier: a single 9x8 unsigned multiplier. Operand muxes are selected by state.

Decomposition:
- Shared package interp_pkg holds:
  - PIX_W, FRAC_W;
  - state enum values IDLE/M0..M5;
  - rounding constant RND = 128;
  - WINDOW_START = 3'd0.
- One natural sub-module, interp_mac: a combinational multiply-add-round, a*b + c (+RND) with an optional >>8. Shared by all six steps.

Test Plan:
- Midpoint blend: p=10/20/30/40, fx=128, fy=128, start at cycle_cnt 0. Expect top=15, bot=35, pix_out=25, with out_valid at cycle_cnt 7.
- Identity corner: fx=0, fy=0, p00=77, others 200. Expect pix_out=77.
- Max weights: fx=255, fy=255, p00=0, p01=p10=p11=255. Expect top=254, bot=255, pix_out=255, with no overflow.
- Divider chain: fx=9 (1/27 from Divider), fy=0, p01=255, others 0. Expect pix_out=9.
- Handshake:
  - in_valid at cycle_cnt 3 while IDLE: ignored, no pulse.
  - in_valid held through a busy window: exactly one pulse per window.
  - 4 back-to-back windows: 4 pulses, spaced 8 cycles apart.
- Reset mid-job: deassert rst_n during M2. Expect immediate pix_out=0, out_valid=0, in_ready=1 after release, and a clean next job.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared constants and FSM encoding for the bilinear interpolator.
// Imported by the interpolator top and by its multiply-add unit.
package interp_pkg;

    localparam int PIX_W  = 8;
    localparam int FRAC_W = 8;
    localparam int RND    = 128;

    localparam logic [2:0] WINDOW_START = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5
    } state_t;

endpackage

// File: rtl/interp_mac.sv
// Combinational multiply-add; the final form of each blend step also
// rounds half-up and drops the fraction bits.
module interp_mac
    import interp_pkg::*;
#(
    parameter int A_W   = 9,
    parameter int B_W   = 8,
    parameter int ACC_W = 17,
    parameter int SH    = 8
) (
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [ACC_W-1:0] c,
    input  logic             fin,
    output logic [ACC_W-1:0] y
);

    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;

    assign prod = ACC_W'(a) * ACC_W'(b);
    assign sum  = prod + c + (fin ? ACC_W'(RND) : '0);
    assign y    = fin ? (sum >> SH) : sum;

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear blend of a 2x2 neighbourhood, one pixel per 8-cycle window,
// sequenced over a single shared multiply-add.
module bilinear_interp #(
    parameter int PIX_W  = interp_pkg::PIX_W,
    parameter int FRAC_W = interp_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cycle_cnt,
    input  logic [FRAC_W-1:0] frac_val,
    input  logic [FRAC_W-1:0] frac_y,
    input  logic [PIX_W-1:0]  p00,
    input  logic [PIX_W-1:0]  p01,
    input  logic [PIX_W-1:0]  p10,
    input  logic [PIX_W-1:0]  p11,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PIX_W-1:0]  pix_out,
    output logic              out_valid
);

    import interp_pkg::*;

    localparam int ACC_W = PIX_W + FRAC_W + 1;
    localparam int WT_W  = FRAC_W + 1;
    localparam logic [WT_W-1:0] ONE = {1'b1, {FRAC_W{1'b0}}};

    state_t state, state_nx;

    logic [PIX_W-1:0]  q00, q01, q10, q11;
    logic [PIX_W-1:0]  top, bot;
    logic [FRAC_W-1:0] fx, fy;
    logic [ACC_W-1:0]  acc;
    logic [WT_W-1:0]   wx0, wy0;
    logic [WT_W-1:0]   mac_a;
    logic [PIX_W-1:0]  mac_b;
    logic [ACC_W-1:0]  mac_c, mac_y;
    logic              mac_fin;
    logic              start;

    assign in_ready = (state == IDLE);
    assign start    = in_ready && in_valid && (cycle_cnt == WINDOW_START);
    assign wx0      = ONE - {1'b0, fx};
    assign wy0      = ONE - {1'b0, fy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = M0;
            M0:      state_nx = M1;
            M1:      state_nx = M2;
            M2:      state_nx = M3;
            M3:      state_nx = M4;
            M4:      state_nx = M5;
            M5:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand select: even steps seed acc, odd steps finish a blend
    always_comb begin
        mac_a   = wx0;
        mac_b   = q00;
        mac_c   = '0;
        mac_fin = 1'b0;
        unique case (state)
            M0: begin mac_a = wx0;           mac_b = q00; end
            M1: begin mac_a = {1'b0, fx};    mac_b = q01;
                      mac_c = acc;           mac_fin = 1'b1; end
            M2: begin mac_a = wx0;           mac_b = q10; end
            M3: begin mac_a = {1'b0, fx};    mac_b = q11;
                      mac_c = acc;           mac_fin = 1'b1; end
            M4: begin mac_a = wy0;           mac_b = top; end
            M5: begin mac_a = {1'b0, fy};    mac_b = bot;
                      mac_c = acc;           mac_fin = 1'b1; end
            default: ;
        endcase
    end

    interp_mac #(
        .A_W   (WT_W),
        .B_W   (PIX_W),
        .ACC_W (ACC_W),
        .SH    (FRAC_W)
    ) u_mac (
        .a   (mac_a),
        .b   (mac_b),
        .c   (mac_c),
        .fin (mac_fin),
        .y   (mac_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q00       <= '0;
            q01       <= '0;
            q10       <= '0;
            q11       <= '0;
            fx        <= '0;
            fy        <= '0;
            acc       <= '0;
            top       <= '0;
            bot       <= '0;
            pix_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (start) begin
                q00 <= p00;
                q01 <= p01;
                q10 <= p10;
                q11 <= p11;
                fx  <= frac_val;
                fy  <= frac_y;
            end
            unique case (state)
                M0, M2, M4: acc <= mac_y;
                M1: top <= mac_y[PIX_W-1:0];
                M3: bot <= mac_y[PIX_W-1:0];
                M5: begin
                    pix_out   <= mac_y[PIX_W-1:0];
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Directed-vector bench for bilinear_interp with hand-computed results.
// The bench owns the free-running window counter.
module tb_bilinear_interp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cycle_cnt;
    logic [7:0] frac_val, frac_y;
    logic [7:0] p00, p01, p10, p11;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pix_out;
    logic       out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int cyc     = 0;
    int last_pulse_cyc = -1;
    int last_pulse_cnt = -1;

    bilinear_interp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cycle_cnt (cycle_cnt),
        .frac_val  (frac_val),
        .frac_y    (frac_y),
        .p00       (p00),
        .p01       (p01),
        .p10       (p10),
        .p11       (p11),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_out   (pix_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock: sample 1ns after the edge, then advance the window counter
    task automatic step();
        @(posedge clk);
        #1;
        cycle_cnt = cycle_cnt + 3'd1;
        cyc++;
        if (out_valid === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
            last_pulse_cnt = int'(cycle_cnt);
        end
    endtask

    task automatic align(input logic [2:0] target);
        int guard = 0;
        while (cycle_cnt != target && guard < 16) begin
            step();
            guard++;
        end
        chk("align", int'(cycle_cnt), int'(target));
    endtask

    task automatic run_job(
        input string      tag,
        input logic [7:0] a00, a01, a10, a11,
        input logic [7:0] fx, fy,
        input int         e_top, e_bot, e_pix,
        input bit         hold
    );
        int p0;
        align(3'd0);
        p00 = a00; p01 = a01; p10 = a10; p11 = a11;
        frac_val = fx; frac_y = fy;
        in_valid = 1'b1;
        p0 = pulses;
        step();
        if (!hold) in_valid = 1'b0;
        // Scramble inputs: results must come from the start-edge capture
        frac_val = ~fx; frac_y = ~fy;
        p00 = 8'hAA; p01 = 8'h55; p10 = 8'h0F; p11 = 8'hF0;
        chk({tag, "_busy"}, int'(in_ready), 0);
        for (int i = 0; i < 6; i++) step();
        in_valid = 1'b0;
        chk({tag, "_ov"}, int'(out_valid), 1);
        chk({tag, "_cnt7"}, last_pulse_cnt, 7);
        chk({tag, "_top"}, int'(dut.top), e_top);
        chk({tag, "_bot"}, int'(dut.bot), e_bot);
        chk({tag, "_pix"}, int'(pix_out), e_pix);
        step();
        chk({tag, "_ov_drop"}, int'(out_valid), 0);
        chk({tag, "_hold"}, int'(pix_out), e_pix);
        chk({tag, "_npulse"}, pulses - p0, 1);
    endtask

    initial begin
        int p0;
        int prev;
        int gap_bad;
        rst_n = 1'b0;
        cycle_cnt = 3'd0;
        frac_val = '0; frac_y = '0;
        p00 = '0; p01 = '0; p10 = '0; p11 = '0;
        in_valid = 1'b0;
        #23;
        chk("rst_pix", int'(pix_out), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_rdy", int'(in_ready), 1);
        rst_n = 1'b1;
        step();

        run_job("mid", 8'd10, 8'd20, 8'd30, 8'd40, 8'd128, 8'd128,
                15, 35, 25, 1'b0);
        run_job("ident", 8'd77, 8'd200, 8'd200, 8'd200, 8'd0, 8'd0,
                77, 200, 77, 1'b0);
        run_job("max", 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
                254, 255, 255, 1'b0);
        run_job("div", 8'd0, 8'd255, 8'd0, 8'd0, 8'd9, 8'd0,
                9, 0, 9, 1'b0);
        run_job("asym", 8'd100, 8'd50, 8'd0, 8'd200, 8'd64, 8'd192,
                88, 50, 60, 1'b0);
        run_job("held", 8'd10, 8'd20, 8'd30, 8'd40, 8'd128, 8'd128,
                15, 35, 25, 1'b1);

        // Request off the window boundary is ignored
        align(3'd3);
        p0 = pulses;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("off_win_rdy", int'(in_ready), 1);
        for (int i = 0; i < 12; i++) step();
        chk("off_win_pulse", pulses - p0, 0);

        // Four back-to-back windows
        align(3'd0);
        p0 = pulses;
        prev = -1;
        gap_bad = 0;
        p00 = 8'd10; p01 = 8'd20; p10 = 8'd30; p11 = 8'd40;
        frac_val = 8'd128; frac_y = 8'd128;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step();
            if (out_valid === 1'b1) begin
                if (prev >= 0 && cyc - prev != 8) gap_bad++;
                prev = cyc;
            end
        end
        in_valid = 1'b0;
        chk("b2b_pulses", pulses - p0, 4);
        chk("b2b_gap", gap_bad, 0);
        chk("b2b_pix", int'(pix_out), 25);

        // Reset during M2 aborts the job
        align(3'd0);
        p00 = 8'd1; p01 = 8'd2; p10 = 8'd3; p11 = 8'd4;
        frac_val = 8'd100; frac_y = 8'd100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_rst_pix", int'(pix_out), 25);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pix", int'(pix_out), 0);
        chk("mid_rst_ov", int'(out_valid), 0);
        chk("mid_rst_acc", int'(dut.acc), 0);
        #1;
        rst_n = 1'b1;
        chk("post_rst_rdy", int'(in_ready), 1);
        p0 = pulses;
        for (int i = 0; i < 10; i++) step();
        chk("post_rst_nopulse", pulses - p0, 0);
        run_job("clean", 8'd100, 8'd50, 8'd0, 8'd200, 8'd64, 8'd192,
                88, 50, 60, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
